// File: rtl/moore_seq_detector_p.sv
// Parametrised Moore sequence detector with a runtime-loadable pattern, overlap select,
// an input-enable qualifier and a saturating match counter. Define SEQDET_STICKY_EN for MATCH_SEEN.
module moore_seq_detector_p #(
    parameter int                   PATTERN_W       = 4,
    parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = 4'b1101,
    parameter int                   CNT_W           = 8
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic                 IN,
    input  logic                 LOAD,
    input  logic [PATTERN_W-1:0] PATTERN,
    input  logic                 OVERLAP,
    output logic                 OUT,
    output logic [CNT_W-1:0]     MATCH_COUNT
`ifdef SEQDET_STICKY_EN
    ,
    output logic                 MATCH_SEEN
`endif
);

    localparam int                FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_SCAN,
        ST_MATCH
    } state_e;

    state_e                 state_q, state_d;
    logic [PATTERN_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [PATTERN_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
`ifdef SEQDET_STICKY_EN
    logic                   seen_q, seen_d;
`endif

    logic [PATTERN_W-1:0]   hist_next;
    logic [FILL_W-1:0]      fill_next;
    logic                   hit;

    // Candidate history and fill count if IN were sampled on this edge.
    assign hist_next = {hist_q[PATTERN_W-2:0], IN};
    assign fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    assign hit       = (hist_next == pat_q) && (fill_next == FILL_FULL);

    always_comb begin
        // NOTE: every signal gets a hold/default value before any branch, so no path leaves one unassigned and no latch is inferred.
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        state_d = (fill_q == FILL_FULL) ? ST_SCAN : ST_FILL;
`ifdef SEQDET_STICKY_EN
        seen_d  = seen_q;
`endif

        if (LOAD) begin
            pat_d   = PATTERN;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
            state_d = ST_FILL;
`ifdef SEQDET_STICKY_EN
            seen_d  = 1'b0;
`endif
        end else if (EN) begin
            hist_d = hist_next;
            if (hit) begin
                state_d = ST_MATCH;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Non-overlapping mode demands a full set of fresh bits before the next match.
                fill_d = OVERLAP ? fill_next : '0;
`ifdef SEQDET_STICKY_EN
                seen_d = 1'b1;
`endif
            end else begin
                fill_d  = fill_next;
                state_d = (fill_next == FILL_FULL) ? ST_SCAN : ST_FILL;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= DEFAULT_PATTERN;
            cnt_q   <= '0;
`ifdef SEQDET_STICKY_EN
            seen_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
`ifdef SEQDET_STICKY_EN
            seen_q  <= seen_d;
`endif
        end
    end

    assign OUT         = (state_q == ST_MATCH);
    assign MATCH_COUNT = cnt_q;
`ifdef SEQDET_STICKY_EN
    assign MATCH_SEEN  = seen_q;
`endif

endmodule

// File: tb/tb_moore_seq_detector_p.sv
// Self-checking bench for moore_seq_detector_p: directed scenarios plus a randomized run
// compared against a queue-based reference model of the sampled bit stream.
module tb_moore_seq_detector_p;

    localparam int           W     = 4;
    localparam int           CW    = 8;
    localparam logic [W-1:0] DEF_P = 4'b1101;

    logic          CLOCK;
    logic          RESET;
    logic          EN;
    logic          IN;
    logic          LOAD;
    logic [W-1:0]  PATTERN;
    logic          OVERLAP;
    logic          OUT;
    logic [CW-1:0] MATCH_COUNT;
`ifdef SEQDET_STICKY_EN
    logic          MATCH_SEEN;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: the bits that count toward the current window, oldest first.
    logic          m_bits[$];
    logic [W-1:0]  m_pat;
    logic [CW-1:0] m_cnt;
    logic          m_out;
    logic          m_seen;

    moore_seq_detector_p #(
        .PATTERN_W      (W),
        .DEFAULT_PATTERN(DEF_P),
        .CNT_W          (CW)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .EN         (EN),
        .IN         (IN),
        .LOAD       (LOAD),
        .PATTERN    (PATTERN),
        .OVERLAP    (OVERLAP),
        .OUT        (OUT),
        .MATCH_COUNT(MATCH_COUNT)
`ifdef SEQDET_STICKY_EN
        ,
        .MATCH_SEEN (MATCH_SEEN)
`endif
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    function automatic logic [W-1:0] window_value();
        logic [W-1:0] v;
        v = '0;
        foreach (m_bits[i]) v = {v[W-2:0], m_bits[i]};
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic b, input logic l,
                              input logic [W-1:0] p, input logic o);
        logic h;
        if (r) begin
            m_bits.delete();
            m_pat  = DEF_P;
            m_cnt  = '0;
            m_out  = 1'b0;
            m_seen = 1'b0;
        end else if (l) begin
            m_bits.delete();
            m_pat  = p;
            m_cnt  = '0;
            m_out  = 1'b0;
            m_seen = 1'b0;
        end else if (e) begin
            m_bits.push_back(b);
            if (m_bits.size() > W) void'(m_bits.pop_front());
            h     = (m_bits.size() == W) && (window_value() == m_pat);
            m_out = h;
            if (h) begin
                if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
                m_seen = 1'b1;
                if (!o) m_bits.delete();
            end
        end else begin
            m_out = 1'b0;
        end
    endtask

    // Drive one edge's inputs, let the clock rise, and return at the following falling edge.
    task automatic step(input logic r, input logic e, input logic b, input logic l,
                        input logic [W-1:0] p, input logic o);
        RESET   = r;
        EN      = e;
        IN      = b;
        LOAD    = l;
        PATTERN = p;
        OVERLAP = o;
        @(posedge CLOCK);
        model_edge(r, e, b, l, p, o);
        @(negedge CLOCK);
    endtask

    task automatic test_reset();
        logic s[3] = '{1'b1, 1'b1, 1'b0};
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        n_total++;
        if (OUT !== 1'b0) $display("FAIL reset_out: got %b expected 0", OUT);
        else n_pass++;
        n_total++;
        if (MATCH_COUNT !== '0) $display("FAIL reset_count: got %0d expected 0", MATCH_COUNT);
        else n_pass++;
`ifdef SEQDET_STICKY_EN
        n_total++;
        if (MATCH_SEEN !== 1'b0) $display("FAIL reset_seen: got %b expected 0", MATCH_SEEN);
        else n_pass++;
`endif
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, s[i], 1'b0, '0, 1'b1);
            n_total++;
            if (OUT !== 1'b0) $display("FAIL reset_partial_out[%0d]: got %b expected 0", i, OUT);
            else n_pass++;
        end
    endtask

    task automatic test_overlap();
        logic s[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic x[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, s[i], 1'b0, '0, 1'b1);
            n_total++;
            if (OUT !== x[i]) $display("FAIL overlap_out[%0d]: got %b expected %b", i, OUT, x[i]);
            else n_pass++;
        end
        n_total++;
        if (MATCH_COUNT !== 8'd2) $display("FAIL overlap_count: got %0d expected 2", MATCH_COUNT);
        else n_pass++;
    endtask

    task automatic test_non_overlap();
        logic s[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic x[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, s[i], 1'b0, '0, 1'b0);
            n_total++;
            if (OUT !== x[i]) $display("FAIL nonoverlap_out[%0d]: got %b expected %b", i, OUT, x[i]);
            else n_pass++;
        end
        n_total++;
        if (MATCH_COUNT !== 8'd1) $display("FAIL nonoverlap_count: got %0d expected 1", MATCH_COUNT);
        else n_pass++;
    endtask

    task automatic test_all_zero();
        logic xo[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic xn[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
            n_total++;
            if (OUT !== xo[i]) $display("FAIL zeros_ovl_out[%0d]: got %b expected %b", i, OUT, xo[i]);
            else n_pass++;
        end
        n_total++;
        if (MATCH_COUNT !== 8'd3) $display("FAIL zeros_ovl_count: got %0d expected 3", MATCH_COUNT);
        else n_pass++;
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
            n_total++;
            if (OUT !== xn[i]) $display("FAIL zeros_novl_out[%0d]: got %b expected %b", i, OUT, xn[i]);
            else n_pass++;
        end
        n_total++;
        if (MATCH_COUNT !== 8'd1) $display("FAIL zeros_novl_count: got %0d expected 1", MATCH_COUNT);
        else n_pass++;
    endtask

    task automatic test_en_gating();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i[0], 1'b0, '0, 1'b1);
            n_total++;
            if (OUT !== 1'b0) $display("FAIL en_gated_out[%0d]: got %b expected 0", i, OUT);
            else n_pass++;
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        n_total++;
        if (OUT !== 1'b0) $display("FAIL en_third_bit_out: got %b expected 0", OUT);
        else n_pass++;
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        n_total++;
        if (OUT !== 1'b1) $display("FAIL en_match_out: got %b expected 1", OUT);
        else n_pass++;
        n_total++;
        if (MATCH_COUNT !== 8'd1) $display("FAIL en_match_count: got %0d expected 1", MATCH_COUNT);
        else n_pass++;
        // With EN low the MATCH pulse must still drop after one cycle.
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        n_total++;
        if (OUT !== 1'b0) $display("FAIL en_pulse_width: got %b expected 0", OUT);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        n_total++;
        if (OUT !== 1'b0) $display("FAIL midreset_out: got %b expected 0", OUT);
        else n_pass++;
        n_total++;
        if (MATCH_COUNT !== 8'd0) $display("FAIL midreset_count: got %0d expected 0", MATCH_COUNT);
        else n_pass++;
    endtask

    task automatic test_saturation();
        bit all_high = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1);
        for (int k = 1; k <= 260; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
            if (k >= 4 && OUT !== 1'b1) all_high = 1'b0;
`ifdef SEQDET_STICKY_EN
            if (k == 4) begin
                n_total++;
                if (MATCH_SEEN !== 1'b1) $display("FAIL sticky_set: got %b expected 1", MATCH_SEEN);
                else n_pass++;
            end
`endif
            if (k == 257) begin
                n_total++;
                if (MATCH_COUNT !== 8'd254) $display("FAIL sat_below: got %0d expected 254", MATCH_COUNT);
                else n_pass++;
            end
            if (k == 258) begin
                n_total++;
                if (MATCH_COUNT !== 8'd255) $display("FAIL sat_reach: got %0d expected 255", MATCH_COUNT);
                else n_pass++;
            end
        end
        n_total++;
        if (!all_high) $display("FAIL sat_out_continuous: got gap expected continuous high");
        else n_pass++;
        n_total++;
        if (MATCH_COUNT !== 8'd255) $display("FAIL sat_hold: got %0d expected 255", MATCH_COUNT);
        else n_pass++;
`ifdef SEQDET_STICKY_EN
        n_total++;
        if (MATCH_SEEN !== 1'b1) $display("FAIL sticky_hold: got %b expected 1", MATCH_SEEN);
        else n_pass++;
`endif
        // LOAD wins over EN: the IN=1 on the load edge must not enter the history.
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
        n_total++;
        if (OUT !== 1'b0 || MATCH_COUNT !== 8'd0)
            $display("FAIL load_clear: got out=%b count=%0d expected out=0 count=0", OUT, MATCH_COUNT);
        else n_pass++;
`ifdef SEQDET_STICKY_EN
        n_total++;
        if (MATCH_SEEN !== 1'b0) $display("FAIL sticky_load_clear: got %b expected 0", MATCH_SEEN);
        else n_pass++;
`endif
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        n_total++;
        if (OUT !== 1'b0) $display("FAIL load_no_sample: got %b expected 0", OUT);
        else n_pass++;
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        n_total++;
        if (OUT !== 1'b1) $display("FAIL load_fourth_bit: got %b expected 1", OUT);
        else n_pass++;
    endtask

    task automatic test_random();
        int fails = 0;
        for (int c = 0; c < 2000; c++) begin
            logic r, e, b, l, o;
            logic [W-1:0] p;
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 3) != 0);
            b = 1'($urandom());
            o = 1'($urandom());
            p = W'($urandom());
            step(r, e, b, l, p, o);
            n_total++;
            if (OUT !== m_out) begin
                if (fails < 10) $display("FAIL rand_out[%0d]: got %b expected %b", c, OUT, m_out);
                fails++;
            end else n_pass++;
            n_total++;
            if (MATCH_COUNT !== m_cnt) begin
                if (fails < 10) $display("FAIL rand_count[%0d]: got %0d expected %0d", c, MATCH_COUNT, m_cnt);
                fails++;
            end else n_pass++;
`ifdef SEQDET_STICKY_EN
            n_total++;
            if (MATCH_SEEN !== m_seen) begin
                if (fails < 10) $display("FAIL rand_seen[%0d]: got %b expected %b", c, MATCH_SEEN, m_seen);
                fails++;
            end else n_pass++;
`endif
        end
    endtask

    initial begin
        RESET   = 1'b1;
        EN      = 1'b0;
        IN      = 1'b0;
        LOAD    = 1'b0;
        PATTERN = '0;
        OVERLAP = 1'b1;
        m_pat   = DEF_P;
        m_cnt   = '0;
        m_out   = 1'b0;
        m_seen  = 1'b0;
        @(negedge CLOCK);
        test_reset();
        test_overlap();
        test_non_overlap();
        test_all_zero();
        test_en_gating();
        test_reset_midstream();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
